pipe_ctrl: RTL and testbench

Central pipeline hazard and sequencing controller for the 5-stage core (if, if_id, id, id_ex, ex, ex_mem, mem, mem_wb).
- Detects load-use hazards on the operands the decode stage reads.
- Sequences multi-cycle divide and bus-wait stalls.
- Arbitrates and issues jump/branch redirects with the matching flushes.
- Drives per-stage stall and flush controls plus a stall-cycle performance counter.

---
 rtl/pipe_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and sequencing controller for the 5-stage core.
//
// Detects load-use hazards on the operands read by decode. It sequences
// multi-cycle divide and bus-wait stalls, issues jump/branch redirects with
// the matching flushes, and counts stalled cycles.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   id_rs*_read_i/addr_i decode operand reads
//   ex_load_i, ex_wen_i, ex_rd_addr_i  producer in ex
//   ex_jump_req_i, ex_jump_addr_i      resolved redirect from ex
//   ex_div_start_i, div_done_i         divide sequencing
//   mem_busy_i          data bus not ready
//   stall_o[4:0]        hold: [0] pc, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb
//   flush_if_id_o, flush_id_ex_o       bubble insertion
//   jump_flag_o, jump_addr_o           pc redirect
//   div_abort_o         divide timeout pulse
//   stall_cnt_o         saturating count of cycles with any stall bit set
module pipe_ctrl #(
  parameter int DIV_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_rs1_read_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic             id_rs2_read_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             ex_load_i,
  input  logic             ex_wen_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_jump_req_i,
  input  logic [31:0]      ex_jump_addr_i,
  input  logic             ex_div_start_i,
  input  logic             div_done_i,
  input  logic             mem_busy_i,
  output logic [4:0]       stall_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic             jump_flag_o,
  output logic [31:0]      jump_addr_o,
  output logic             div_abort_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_WAIT = 2'd1,
    BUS_WAIT = 2'd2
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(DIV_TIMEOUT - 1);

  localparam logic [4:0] STALL_LOAD = 5'b00011;
  localparam logic [4:0] STALL_DIV  = 5'b01111;
  localparam logic [4:0] STALL_BUS  = 5'b11111;

  state_t           state_reg, state_next;
  logic             pend_vld_reg, pend_vld_next;
  logic [31:0]      pend_addr_reg, pend_addr_next;
  logic [7:0]       div_cnt_reg, div_cnt_next;
  // A done pulse that arrives while the bus also stalls is remembered
  // so the divide still completes once the bus frees up.
  logic             done_pend_reg, done_pend_next;
  logic [CNT_W-1:0] stall_cnt_reg;

  logic [4:0]  stall_c;
  logic        flush_if_id_c;
  logic        flush_id_ex_c;
  logic        jump_flag_c;
  logic [31:0] jump_addr_c;
  logic        div_abort_c;

  // Per-operand match against the ex destination.
  logic [1:0] src_read;
  logic [4:0] src_addr [2];
  logic [1:0] src_hit;
  logic       load_use;

  assign src_read    = {id_rs2_read_i, id_rs1_read_i};
  assign src_addr[0] = id_rs1_addr_i;
  assign src_addr[1] = id_rs2_addr_i;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_read[gi] & (src_addr[gi] == ex_rd_addr_i);
    end
  endgenerate

  assign load_use = ex_load_i & ex_wen_i & (ex_rd_addr_i != 5'd0) & (|src_hit);

  // The divide counter stops at its last value so a bus stall that overlaps
  // the timeout cycle defers the abort instead of overshooting it.
  logic [7:0] div_cnt_inc;
  assign div_cnt_inc = (div_cnt_reg == DIV_LAST) ? div_cnt_reg : div_cnt_reg + 8'd1;

  always_comb begin
    state_next     = state_reg;
    pend_vld_next  = pend_vld_reg;
    pend_addr_next = pend_addr_reg;
    div_cnt_next   = div_cnt_reg;
    done_pend_next = done_pend_reg;
    stall_c        = 5'b00000;
    flush_if_id_c  = 1'b0;
    flush_id_ex_c  = 1'b0;
    jump_flag_c    = 1'b0;
    jump_addr_c    = 32'd0;
    div_abort_c    = 1'b0;

    case (state_reg)
      // BUS_WAIT behaves exactly like RUN once the bus is free, so both
      // states share one decision tree.
      RUN, BUS_WAIT: begin
        if (mem_busy_i) begin
          stall_c    = STALL_BUS;
          state_next = BUS_WAIT;
          if (ex_jump_req_i) begin
            pend_vld_next  = 1'b1;
            pend_addr_next = ex_jump_addr_i;
          end
        end else begin
          state_next = RUN;
          if (pend_vld_reg) begin
            // The live request, if any, is the same held instruction.
            jump_flag_c   = 1'b1;
            jump_addr_c   = pend_addr_reg;
            flush_if_id_c = 1'b1;
            flush_id_ex_c = 1'b1;
            pend_vld_next = 1'b0;
          end else if (ex_jump_req_i) begin
            jump_flag_c   = 1'b1;
            jump_addr_c   = ex_jump_addr_i;
            flush_if_id_c = 1'b1;
            flush_id_ex_c = 1'b1;
          end else if (ex_div_start_i) begin
            stall_c        = STALL_DIV;
            state_next     = DIV_WAIT;
            div_cnt_next   = 8'd0;
            done_pend_next = 1'b0;
          end else if (load_use) begin
            // One bubble suffices: the mem-stage forward covers the next cycle.
            stall_c       = STALL_LOAD;
            flush_id_ex_c = 1'b1;
          end
        end
      end

      DIV_WAIT: begin
        if (mem_busy_i) begin
          stall_c        = STALL_BUS;
          div_cnt_next   = div_cnt_inc;
          done_pend_next = done_pend_reg | div_done_i;
        end else if (div_done_i | done_pend_reg) begin
          state_next     = RUN;
          done_pend_next = 1'b0;
        end else if (div_cnt_reg == DIV_LAST) begin
          div_abort_c = 1'b1;
          state_next  = RUN;
        end else begin
          stall_c      = STALL_DIV;
          div_cnt_next = div_cnt_inc;
        end
      end

      default: begin
        state_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RUN;
      pend_vld_reg  <= 1'b0;
      pend_addr_reg <= 32'd0;
      div_cnt_reg   <= 8'd0;
      done_pend_reg <= 1'b0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      pend_vld_reg  <= pend_vld_next;
      pend_addr_reg <= pend_addr_next;
      div_cnt_reg   <= div_cnt_next;
      done_pend_reg <= done_pend_next;
      if ((|stall_c) && (stall_cnt_reg != {CNT_W{1'b1}})) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
    end
  end

  // Every output reads as zero while reset is held.
  assign stall_o       = rst ? 5'b00000 : stall_c;
  assign flush_if_id_o = ~rst & flush_if_id_c;
  assign flush_id_ex_o = ~rst & flush_id_ex_c;
  assign jump_flag_o   = ~rst & jump_flag_c;
  assign jump_addr_o   = rst ? 32'd0 : jump_addr_c;
  assign div_abort_o   = ~rst & div_abort_c;
  assign stall_cnt_o   = rst ? '0 : stall_cnt_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_rs1_read, id_rs2_read;
  logic [4:0]  id_rs1_addr, id_rs2_addr;
  logic        ex_load, ex_wen;
  logic [4:0]  ex_rd_addr;
  logic        ex_jump_req;
  logic [31:0] ex_jump_addr;
  logic        ex_div_start, div_done, mem_busy;

  logic [4:0]  stall;
  logic        flush_if_id, flush_id_ex, jump_flag, div_abort;
  logic [31:0] jump_addr;
  logic [31:0] stall_cnt;

  logic [4:0]  d8_stall;
  logic        d8_flush_if_id, d8_flush_id_ex, d8_jump_flag, d8_div_abort;
  logic [31:0] d8_jump_addr;
  logic [3:0]  d8_stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.DIV_TIMEOUT(16), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .id_rs1_read_i(id_rs1_read), .id_rs1_addr_i(id_rs1_addr),
    .id_rs2_read_i(id_rs2_read), .id_rs2_addr_i(id_rs2_addr),
    .ex_load_i(ex_load), .ex_wen_i(ex_wen), .ex_rd_addr_i(ex_rd_addr),
    .ex_jump_req_i(ex_jump_req), .ex_jump_addr_i(ex_jump_addr),
    .ex_div_start_i(ex_div_start), .div_done_i(div_done), .mem_busy_i(mem_busy),
    .stall_o(stall), .flush_if_id_o(flush_if_id), .flush_id_ex_o(flush_id_ex),
    .jump_flag_o(jump_flag), .jump_addr_o(jump_addr), .div_abort_o(div_abort),
    .stall_cnt_o(stall_cnt)
  );

  // Short timeout and narrow counter to reach the abort and saturation limits.
  pipe_ctrl #(.DIV_TIMEOUT(8), .CNT_W(4)) u_dut8 (
    .clk(clk), .rst(rst),
    .id_rs1_read_i(id_rs1_read), .id_rs1_addr_i(id_rs1_addr),
    .id_rs2_read_i(id_rs2_read), .id_rs2_addr_i(id_rs2_addr),
    .ex_load_i(ex_load), .ex_wen_i(ex_wen), .ex_rd_addr_i(ex_rd_addr),
    .ex_jump_req_i(ex_jump_req), .ex_jump_addr_i(ex_jump_addr),
    .ex_div_start_i(ex_div_start), .div_done_i(div_done), .mem_busy_i(mem_busy),
    .stall_o(d8_stall), .flush_if_id_o(d8_flush_if_id), .flush_id_ex_o(d8_flush_id_ex),
    .jump_flag_o(d8_jump_flag), .jump_addr_o(d8_jump_addr), .div_abort_o(d8_div_abort),
    .stall_cnt_o(d8_stall_cnt)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    id_rs1_read = 0; id_rs1_addr = 0; id_rs2_read = 0; id_rs2_addr = 0;
    ex_load = 0; ex_wen = 0; ex_rd_addr = 0;
    ex_jump_req = 0; ex_jump_addr = 0;
    ex_div_start = 0; div_done = 0; mem_busy = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clr_inputs();
    mem_busy = 1; ex_jump_req = 1; ex_jump_addr = 32'h1111_2222;
    cyc();
    @(negedge clk);
    n_tests++;
    if ({stall, flush_if_id, flush_id_ex, jump_flag, div_abort} !== 9'd0 || jump_addr !== 32'd0) begin
      n_fail++; $display("FAIL rst_outputs: got stall=%b fl=%b%b jf=%b ab=%b addr=%h want all 0",
                         stall, flush_if_id, flush_id_ex, jump_flag, div_abort, jump_addr);
    end
    n_tests++;
    if (stall_cnt !== 32'd0) begin
      n_fail++; $display("FAIL rst_cnt: got %0d want 0", stall_cnt);
    end
    cyc();
    rst = 1'b0;
    clr_inputs();
    @(negedge clk);
    n_tests++;
    if (stall !== 5'b00000 || jump_flag !== 1'b0 || stall_cnt !== 32'd0) begin
      n_fail++; $display("FAIL rst_release: got stall=%b jf=%b cnt=%0d want 0/0/0", stall, jump_flag, stall_cnt);
    end
    $display("[TB] reset checked");
    cyc();
  endtask

  task automatic test_load_use();
    ex_load = 1; ex_wen = 1; ex_rd_addr = 5;
    id_rs1_read = 1; id_rs1_addr = 7; id_rs2_read = 1; id_rs2_addr = 5;
    @(negedge clk);
    n_tests++;
    if (stall !== 5'b00011 || flush_id_ex !== 1'b1 || flush_if_id !== 1'b0 || jump_flag !== 1'b0) begin
      n_fail++; $display("FAIL lu_hit: got stall=%b fid=%b fif=%b jf=%b want 00011/1/0/0",
                         stall, flush_id_ex, flush_if_id, jump_flag);
    end
    cyc();
    exp_cnt = 1;
    ex_load = 0;
    @(negedge clk);
    n_tests++;
    if (stall !== 5'b00000 || stall_cnt !== 32'(exp_cnt)) begin
      n_fail++; $display("FAIL lu_next: got stall=%b cnt=%0d want 00000/%0d", stall, stall_cnt, exp_cnt);
    end
    cyc();
    ex_load = 1; ex_rd_addr = 5; id_rs2_read = 0; id_rs2_addr = 5; id_rs1_read = 1; id_rs1_addr = 6;
    @(negedge clk);
    n_tests++;
    if (stall !== 5'b00000) begin
      n_fail++; $display("FAIL lu_noread: got stall=%b want 00000", stall);
    end
    cyc();
    ex_rd_addr = 0; id_rs1_read = 1; id_rs1_addr = 0;
    @(negedge clk);
    n_tests++;
    if (stall !== 5'b00000 || flush_id_ex !== 1'b0) begin
      n_fail++; $display("FAIL lu_x0: got stall=%b fid=%b want 00000/0", stall, flush_id_ex);
    end
    cyc();
    clr_inputs();
    @(negedge clk);
    n_tests++;
    if (stall_cnt !== 32'(exp_cnt)) begin
      n_fail++; $display("FAIL lu_cnt: got %0d want %0d", stall_cnt, exp_cnt);
    end
    $display("[TB] load-use checked, stall_cnt=%0d", stall_cnt);
    cyc();
  endtask

  task automatic test_jump();
    ex_jump_req = 1; ex_jump_addr = 32'h8000_0040;
    ex_load = 1; ex_wen = 1; ex_rd_addr = 3; id_rs1_read = 1; id_rs1_addr = 3;
    @(negedge clk);
    n_tests++;
    if (jump_flag !== 1'b1 || jump_addr !== 32'h8000_0040) begin
      n_fail++; $display("FAIL jmp_flag: got jf=%b addr=%h want 1/80000040", jump_flag, jump_addr);
    end
    n_tests++;
    if (flush_if_id !== 1'b1 || flush_id_ex !== 1'b1 || stall !== 5'b00000) begin
      n_fail++; $display("FAIL jmp_flush: got fif=%b fid=%b stall=%b want 1/1/00000",
                         flush_if_id, flush_id_ex, stall);
    end
    cyc();
    clr_inputs();
    @(negedge clk);
    n_tests++;
    if (jump_flag !== 1'b0 || flush_if_id !== 1'b0) begin
      n_fail++; $display("FAIL jmp_pulse: got jf=%b fif=%b want 0/0", jump_flag, flush_if_id);
    end
    $display("[TB] jump checked");
    cyc();
  endtask

  task automatic test_bus_jump();
    mem_busy = 1; ex_jump_req = 1; ex_jump_addr = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (stall !== 5'b11111 || jump_flag !== 1'b0 || flush_if_id !== 1'b0 || flush_id_ex !== 1'b0) begin
        n_fail++; $display("FAIL bus_hold[%0d]: got stall=%b jf=%b fl=%b%b want 11111/0/00",
                           i, stall, jump_flag, flush_if_id, flush_id_ex);
      end
      cyc();
    end
    exp_cnt += 3;
    mem_busy = 0; ex_jump_addr = 32'hDEAD_BEEF;
    @(negedge clk);
    n_tests++;
    if (jump_flag !== 1'b1 || jump_addr !== 32'h1234_5678 || stall !== 5'b00000) begin
      n_fail++; $display("FAIL bus_pend: got jf=%b addr=%h stall=%b want 1/12345678/00000",
                         jump_flag, jump_addr, stall);
    end
    n_tests++;
    if (flush_if_id !== 1'b1 || flush_id_ex !== 1'b1) begin
      n_fail++; $display("FAIL bus_pend_flush: got %b%b want 11", flush_if_id, flush_id_ex);
    end
    cyc();
    clr_inputs();
    @(negedge clk);
    n_tests++;
    if (jump_flag !== 1'b0 || stall_cnt !== 32'(exp_cnt)) begin
      n_fail++; $display("FAIL bus_after: got jf=%b cnt=%0d want 0/%0d", jump_flag, stall_cnt, exp_cnt);
    end
    $display("[TB] bus-wait jump checked, stall_cnt=%0d", stall_cnt);
    cyc();
  endtask

  task automatic test_div();
    ex_div_start = 1;
    @(negedge clk);
    n_tests++;
    if (stall !== 5'b01111) begin
      n_fail++; $display("FAIL div_start: got %b want 01111", stall);
    end
    cyc();
    ex_div_start = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      n_tests++;
      if (stall !== 5'b01111) begin
        n_fail++; $display("FAIL div_wait[%0d]: got %b want 01111", i, stall);
      end
      cyc();
    end
    div_done = 1;
    @(negedge clk);
    n_tests++;
    if (stall !== 5'b00000 || div_abort !== 1'b0) begin
      n_fail++; $display("FAIL div_done: got stall=%b ab=%b want 00000/0", stall, div_abort);
    end
    cyc();
    div_done = 0;
    exp_cnt += 10;
    @(negedge clk);
    n_tests++;
    if (stall !== 5'b00000 || stall_cnt !== 32'(exp_cnt)) begin
      n_fail++; $display("FAIL div_cnt: got stall=%b cnt=%0d want 00000/%0d", stall, stall_cnt, exp_cnt);
    end
    $display("[TB] divide checked, stall_cnt=%0d", stall_cnt);
    cyc();
  endtask

  task automatic test_div_busy();
    logic [4:0] exp_stall [6];
    exp_stall[0] = 5'b01111; exp_stall[1] = 5'b01111; exp_stall[2] = 5'b01111;
    exp_stall[3] = 5'b11111; exp_stall[4] = 5'b01111; exp_stall[5] = 5'b00000;
    for (int i = 0; i < 6; i++) begin
      ex_div_start = (i == 0);
      mem_busy     = (i == 3);
      div_done     = (i == 5);
      @(negedge clk);
      n_tests++;
      if (stall !== exp_stall[i]) begin
        n_fail++; $display("FAIL divbus[%0d]: got %b want %b", i, stall, exp_stall[i]);
      end
      cyc();
    end
    clr_inputs();
    exp_cnt += 5;
    @(negedge clk);
    n_tests++;
    if (stall !== 5'b00000 || stall_cnt !== 32'(exp_cnt)) begin
      n_fail++; $display("FAIL divbus_end: got stall=%b cnt=%0d want 00000/%0d", stall, stall_cnt, exp_cnt);
    end
    $display("[TB] divide with bus pulse checked, stall_cnt=%0d", stall_cnt);
    cyc();
  endtask

  task automatic test_div_timeout();
    ex_div_start = 1;
    @(negedge clk);
    n_tests++;
    if (d8_stall !== 5'b01111) begin
      n_fail++; $display("FAIL to_start: got %b want 01111", d8_stall);
    end
    cyc();
    ex_div_start = 0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      n_tests++;
      if (d8_stall !== 5'b01111 || d8_div_abort !== 1'b0) begin
        n_fail++; $display("FAIL to_wait[%0d]: got stall=%b ab=%b want 01111/0", i, d8_stall, d8_div_abort);
      end
      cyc();
    end
    @(negedge clk);
    n_tests++;
    if (d8_div_abort !== 1'b1 || d8_stall !== 5'b00000) begin
      n_fail++; $display("FAIL to_abort: got ab=%b stall=%b want 1/00000", d8_div_abort, d8_stall);
    end
    n_tests++;
    if (stall !== 5'b01111 || div_abort !== 1'b0) begin
      n_fail++; $display("FAIL to_long: got stall=%b ab=%b want 01111/0", stall, div_abort);
    end
    cyc();
    @(negedge clk);
    n_tests++;
    if (d8_div_abort !== 1'b0 || d8_stall !== 5'b00000) begin
      n_fail++; $display("FAIL to_pulse: got ab=%b stall=%b want 0/00000", d8_div_abort, d8_stall);
    end
    cyc();
    div_done = 1;
    @(negedge clk);
    n_tests++;
    if (d8_stall !== 5'b00000 || d8_div_abort !== 1'b0 || stall !== 5'b00000) begin
      n_fail++; $display("FAIL to_stray: got d8=%b ab=%b stall=%b want 00000/0/00000",
                         d8_stall, d8_div_abort, stall);
    end
    cyc();
    div_done = 0;
    exp_cnt += 10;
    ex_load = 1; ex_wen = 1; ex_rd_addr = 9; id_rs1_read = 1; id_rs1_addr = 9;
    @(negedge clk);
    n_tests++;
    if (d8_stall !== 5'b00011 || stall !== 5'b00011) begin
      n_fail++; $display("FAIL to_run: got d8=%b stall=%b want 00011/00011", d8_stall, stall);
    end
    cyc();
    clr_inputs();
    exp_cnt += 1;
    @(negedge clk);
    n_tests++;
    if (stall_cnt !== 32'(exp_cnt)) begin
      n_fail++; $display("FAIL to_cnt: got %0d want %0d", stall_cnt, exp_cnt);
    end
    n_tests++;
    if (d8_stall_cnt !== 4'hF) begin
      n_fail++; $display("FAIL cnt_sat: got %0d want 15", d8_stall_cnt);
    end
    $display("[TB] divide timeout checked, stall_cnt=%0d narrow=%0d", stall_cnt, d8_stall_cnt);
    cyc();
  endtask

  task automatic test_reset_bus();
    mem_busy = 1; ex_jump_req = 1; ex_jump_addr = 32'hCAFE_F00D;
    @(negedge clk);
    n_tests++;
    if (stall !== 5'b11111) begin
      n_fail++; $display("FAIL rb_busy: got %b want 11111", stall);
    end
    cyc();
    rst = 1;
    @(negedge clk);
    n_tests++;
    if (stall !== 5'b00000 || jump_flag !== 1'b0 || flush_if_id !== 1'b0 || stall_cnt !== 32'd0) begin
      n_fail++; $display("FAIL rb_held: got stall=%b jf=%b fif=%b cnt=%0d want 0",
                         stall, jump_flag, flush_if_id, stall_cnt);
    end
    cyc();
    rst = 0;
    clr_inputs();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if (jump_flag !== 1'b0 || stall !== 5'b00000 || stall_cnt !== 32'd0 || d8_stall_cnt !== 4'd0) begin
        n_fail++; $display("FAIL rb_after[%0d]: got jf=%b stall=%b cnt=%0d/%0d want 0/00000/0/0",
                           i, jump_flag, stall, stall_cnt, d8_stall_cnt);
      end
      cyc();
    end
    $display("[TB] reset during bus wait checked");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_jump();
    test_bus_jump();
    test_div();
    test_div_busy();
    test_div_timeout();
    test_reset_bus();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
